// File: rtl/traffic_phase_sequencer.sv
// -----------------------------------------------------------------------------
// traffic_phase_sequencer
// Multi-phase traffic signal controller. It cycles GREEN -> YELLOW -> ALLRED
// through the demanded phases. Phase 0 is always served. A night-mode request
// switches the controller into flashing operation.
//
// Ports
//   clk         : sole clock, rising edge
//   rst         : synchronous active-low reset
//   green_time  : per-phase green duration in ticks (CNT_W bits per phase)
//   demand      : per-phase service request (bit 0 ignored, phase 0 always served)
//   night_mode  : request for flashing operation
//   light       : per-phase lamps {red, yellow, green}, 3 bits per phase
//   phase       : active phase index
//   ps          : state (0 ALLRED, 1 GREEN, 2 YELLOW, 3 FLASH)
//   count       : remaining ticks in the current state minus one
// -----------------------------------------------------------------------------
module traffic_phase_sequencer #(
    parameter int unsigned N_PHASE   = 4,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned TICK_DIV  = 1,
    parameter int unsigned T_YEL     = 3,
    parameter int unsigned T_RED_CLR = 1
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [N_PHASE*CNT_W-1:0]                          green_time,
    input  logic [N_PHASE-1:0]                                demand,
    input  logic                                              night_mode,
    output logic [N_PHASE*3-1:0]                              light,
    output logic [((N_PHASE > 1) ? $clog2(N_PHASE) : 1)-1:0]  phase,
    output logic [1:0]                                        ps,
    output logic [CNT_W-1:0]                                  count
);

    localparam int unsigned PH_W  = (N_PHASE > 1) ? $clog2(N_PHASE) : 1;
    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_FLASH  = 2'd3
    } state_t;

    state_t               r_state,  w_state_n;
    logic [PH_W-1:0]      r_phase,  w_phase_n;
    logic [CNT_W-1:0]     r_count,  w_count_n;
    logic                 r_blink,  w_blink_n;
    logic                 r_force0, w_force0_n;
    logic [DIV_W-1:0]     r_div,    w_div_n;
    logic [N_PHASE*3-1:0] r_light,  w_light_n;

    logic                 w_tick;
    logic [N_PHASE-1:0]   w_req;
    logic [PH_W-1:0]      w_nxt_phase;
    logic [PH_W-1:0]      w_tgt_phase;
    logic [CNT_W-1:0]     w_gt_arr [N_PHASE];
    logic [CNT_W-1:0]     w_gt;
    logic [CNT_W-1:0]     w_gt_m1;

    // Timing tick divider
    assign w_tick  = (r_div == DIV_W'(TICK_DIV - 1));
    assign w_div_n = w_tick ? '0 : r_div + DIV_W'(1);

    // Cyclic search from phase+1. Walking k downwards lets the nearest hit win.
    assign w_req = demand | N_PHASE'(1);

    always_comb begin
        w_nxt_phase = '0;
        for (int unsigned k = N_PHASE; k >= 1; k--) begin
            if (w_req[PH_W'((32'(r_phase) + k) % N_PHASE)]) begin
                w_nxt_phase = PH_W'((32'(r_phase) + k) % N_PHASE);
            end
        end
    end

    // After reset or flashing, service restarts at phase 0 regardless of demand
    assign w_tgt_phase = r_force0 ? '0 : w_nxt_phase;

    for (genvar g = 0; g < int'(N_PHASE); g++) begin : g_gt
        assign w_gt_arr[g] = green_time[CNT_W*g +: CNT_W];
    end

    // A zero green time behaves as one tick, so it loads a count of zero
    assign w_gt    = w_gt_arr[w_tgt_phase];
    assign w_gt_m1 = (w_gt == '0) ? '0 : w_gt - CNT_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_ALLRED;
            r_phase  <= '0;
            r_count  <= CNT_W'(T_RED_CLR - 1);
            r_blink  <= 1'b0;
            r_force0 <= 1'b1;
            r_div    <= '0;
            r_light  <= {N_PHASE{3'b100}};
        end else begin
            r_state  <= w_state_n;
            r_phase  <= w_phase_n;
            r_count  <= w_count_n;
            r_blink  <= w_blink_n;
            r_force0 <= w_force0_n;
            r_div    <= w_div_n;
            r_light  <= w_light_n;
        end
    end

    // Next-state logic. Everything advances only on a tick.
    always_comb begin
        w_state_n  = r_state;
        w_phase_n  = r_phase;
        w_count_n  = r_count;
        w_blink_n  = r_blink;
        w_force0_n = r_force0;

        if (w_tick) begin
            case (r_state)
                ST_ALLRED: begin
                    if (r_count != '0) begin
                        w_count_n = r_count - CNT_W'(1);
                    end else if (night_mode) begin
                        w_state_n = ST_FLASH;
                        w_count_n = '0;
                        w_blink_n = 1'b1;
                    end else begin
                        w_state_n  = ST_GREEN;
                        w_phase_n  = w_tgt_phase;
                        w_count_n  = w_gt_m1;
                        w_force0_n = 1'b0;
                    end
                end
                ST_GREEN: begin
                    if (r_count != '0) begin
                        w_count_n = r_count - CNT_W'(1);
                    end else if ((w_nxt_phase == r_phase) && !night_mode) begin
                        // Sole demanded phase keeps the green, no yellow
                        w_count_n = w_gt_m1;
                    end else begin
                        w_state_n = ST_YELLOW;
                        w_count_n = CNT_W'(T_YEL - 1);
                    end
                end
                ST_YELLOW: begin
                    if (r_count != '0) begin
                        w_count_n = r_count - CNT_W'(1);
                    end else begin
                        w_state_n = ST_ALLRED;
                        w_count_n = CNT_W'(T_RED_CLR - 1);
                    end
                end
                ST_FLASH: begin
                    if (!night_mode) begin
                        w_state_n  = ST_ALLRED;
                        w_phase_n  = '0;
                        w_force0_n = 1'b1;
                        w_count_n  = CNT_W'(T_RED_CLR - 1);
                    end else begin
                        w_blink_n = ~r_blink;
                    end
                end
                default: begin
                    w_state_n = ST_ALLRED;
                    w_count_n = CNT_W'(T_RED_CLR - 1);
                end
            endcase
        end
    end

    // Lamp decode from the next state so that light is registered with ps.
    // Only the active phase can be green, so two greens cannot occur.
    always_comb begin
        w_light_n = '0;
        for (int unsigned p = 0; p < N_PHASE; p++) begin
            if (w_state_n == ST_FLASH) begin
                if (!w_blink_n) begin
                    w_light_n[3*p +: 3] = 3'b000;
                end else if (p == 0) begin
                    w_light_n[3*p +: 3] = 3'b010;
                end else begin
                    w_light_n[3*p +: 3] = 3'b100;
                end
            end else if ((32'(w_phase_n) == p) && (w_state_n == ST_GREEN)) begin
                w_light_n[3*p +: 3] = 3'b001;
            end else if ((32'(w_phase_n) == p) && (w_state_n == ST_YELLOW)) begin
                w_light_n[3*p +: 3] = 3'b010;
            end else begin
                w_light_n[3*p +: 3] = 3'b100;
            end
        end
    end

    assign light = r_light;
    assign phase = r_phase;
    assign ps    = r_state;
    assign count = r_count;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_traffic_phase_sequencer
// Directed bench. It drives two instances from the same stimulus. One runs
// with TICK_DIV=1 and the other with TICK_DIV=4. Outputs are compared on the
// falling edge against hand-derived timelines.
// -----------------------------------------------------------------------------
module tb_traffic_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] green_time;
    logic [3:0]  demand;
    logic        night_mode;

    logic [11:0] light1, light4;
    logic [1:0]  phase1, phase4;
    logic [1:0]  ps1, ps4;
    logic [3:0]  count1, count4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    traffic_phase_sequencer #(
        .N_PHASE(4), .CNT_W(4), .TICK_DIV(1), .T_YEL(3), .T_RED_CLR(1)
    ) dut (
        .clk(clk), .rst(rst), .green_time(green_time), .demand(demand),
        .night_mode(night_mode), .light(light1), .phase(phase1), .ps(ps1),
        .count(count1)
    );

    traffic_phase_sequencer #(
        .N_PHASE(4), .CNT_W(4), .TICK_DIV(4), .T_YEL(3), .T_RED_CLR(1)
    ) dut4 (
        .clk(clk), .rst(rst), .green_time(green_time), .demand(demand),
        .night_mode(night_mode), .light(light4), .phase(phase4), .ps(ps4),
        .count(count4)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Hold reset for two edges, release, and stop at the first sample after release (cycle 0)
    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [11:0] exp_light(input logic [1:0] s, input int p);
        logic [11:0] l;
        l = 12'h924;
        if (s == 2'd1) l[3*p +: 3] = 3'b001;
        if (s == 2'd2) l[3*p +: 3] = 3'b010;
        return l;
    endfunction

    // Expected rotation slot with 5 green, 3 yellow and 1 all-red cycles
    task automatic slot(input int r, output logic [1:0] s, output logic [3:0] c);
        if (r < 5) begin
            s = 2'd1; c = 4'(4 - r);
        end else if (r < 8) begin
            s = 2'd2; c = 4'(7 - r);
        end else begin
            s = 2'd0; c = 4'd0;
        end
    endtask

    task automatic check_main(input string tag, input int c, input logic [1:0] s,
                              input int p, input logic [3:0] cn);
        check($sformatf("%s_ps c=%0d", tag, c), 32'(ps1), 32'(s));
        check($sformatf("%s_phase c=%0d", tag, c), 32'(phase1), 32'(p));
        check($sformatf("%s_count c=%0d", tag, c), 32'(count1), 32'(cn));
        check($sformatf("%s_light c=%0d", tag, c), 32'(light1), 32'(exp_light(s, p)));
    endtask

    logic [1:0] es;
    logic [3:0] ec;
    int         ep;

    logic [1:0] z_ps [15] = '{2'd1,2'd1,2'd1,2'd1,2'd1,2'd2,2'd2,2'd2,2'd0,
                              2'd1,2'd2,2'd2,2'd2,2'd0,2'd1};
    int         z_ph [15] = '{0,0,0,0,0,0,0,0,0,2,2,2,2,2,0};
    logic [3:0] z_ct [15] = '{4'd4,4'd3,4'd2,4'd1,4'd0,4'd2,4'd1,4'd0,4'd0,
                              4'd0,4'd2,4'd1,4'd0,4'd0,4'd4};

    initial begin
        rst        = 1'b0;
        green_time = 16'h5555;
        demand     = 4'b0000;
        night_mode = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_light", 32'(light1), 32'h924);
        check("rst_ps", 32'(ps1), 32'd0);
        check("rst_phase", 32'(phase1), 32'd0);
        check("rst_count", 32'(count1), 32'd0);
        check("rst_light_div4", 32'(light4), 32'h924);
        rst = 1'b1;
        @(negedge clk);
        check("rel_ps", 32'(ps1), 32'd1);
        check("rel_light", 32'(light1), 32'h921);
        check("rel_count", 32'(count1), 32'd4);

        // Full rotation 0,1,2,3,0 with a 36-cycle period, plus the divided instance
        demand = 4'b1110;
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            slot((c % 36) % 9, es, ec);
            check_main("rot", c, es, (c % 36) / 9, ec);
            case (c)
                2:  check("d4_allred c=2", 32'(ps4), 32'd0);
                3:  begin
                        check("d4_green c=3", 32'(ps4), 32'd1);
                        check("d4_cnt c=3", 32'(count4), 32'd4);
                        check("d4_light c=3", 32'(light4), 32'h921);
                    end
                6:  check("d4_cnt c=6", 32'(count4), 32'd4);
                7:  check("d4_cnt c=7", 32'(count4), 32'd3);
                22: begin
                        check("d4_green c=22", 32'(ps4), 32'd1);
                        check("d4_cnt c=22", 32'(count4), 32'd0);
                    end
                23: begin
                        check("d4_yel c=23", 32'(ps4), 32'd2);
                        check("d4_cnt c=23", 32'(count4), 32'd2);
                    end
                34: check("d4_yel c=34", 32'(ps4), 32'd2);
                35: check("d4_allred c=35", 32'(ps4), 32'd0);
                38: check("d4_allred c=38", 32'(ps4), 32'd0);
                39: begin
                        check("d4_green c=39", 32'(ps4), 32'd1);
                        check("d4_phase c=39", 32'(phase4), 32'd1);
                        check("d4_cnt c=39", 32'(count4), 32'd4);
                    end
                default: ;
            endcase
            @(negedge clk);
        end

        // Skip (0,2,0) and then hold phase 0 with no demand
        demand = 4'b0100;
        do_reset();
        for (int c = 0; c <= 30; c++) begin
            if (c < 18) begin
                slot(c % 9, es, ec);
                ep = (c < 9) ? 0 : 2;
            end else begin
                es = 2'd1;
                ec = 4'(4 - ((c - 18) % 5));
                ep = 0;
            end
            check_main("skip", c, es, ep, ec);
            if (c == 18) demand = 4'b0000;
            @(negedge clk);
        end

        // Night mode requested mid-green of phase 1
        demand = 4'b1110;
        do_reset();
        for (int c = 0; c <= 27; c++) begin
            if (c < 18) begin
                slot(c % 9, es, ec);
                check_main("night", c, es, c / 9, ec);
            end else if (c <= 25) begin
                check($sformatf("flash_ps c=%0d", c), 32'(ps1), 32'd3);
                check($sformatf("flash_light c=%0d", c), 32'(light1),
                      ((c - 18) % 2 == 0) ? 32'h922 : 32'h000);
            end else if (c == 26) begin
                check("unflash_ps", 32'(ps1), 32'd0);
                check("unflash_phase", 32'(phase1), 32'd0);
                check("unflash_light", 32'(light1), 32'h924);
            end else begin
                check_main("unflash", c, 2'd1, 0, 4'd4);
            end
            if (c == 11) night_mode = 1'b1;
            if (c == 25) night_mode = 1'b0;
            @(negedge clk);
        end

        // Zero green time on phase 2 gives a one-tick green
        green_time = 16'h5055;
        demand     = 4'b0100;
        do_reset();
        for (int c = 0; c < 15; c++) begin
            check_main("zero", c, z_ps[c], z_ph[c], z_ct[c]);
            @(negedge clk);
        end
        green_time = 16'h5555;

        // Reset during phase 3 yellow
        demand = 4'b1110;
        do_reset();
        repeat (33) @(negedge clk);
        check("pre_rst_ps", 32'(ps1), 32'd2);
        check("pre_rst_phase", 32'(phase1), 32'd3);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_light", 32'(light1), 32'h924);
        check("mid_rst_ps", 32'(ps1), 32'd0);
        check("mid_rst_phase", 32'(phase1), 32'd0);
        check("mid_rst_count", 32'(count1), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_main("post_rst", 0, 2'd1, 0, 4'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_phase_sequencer.md
TRAFFIC_PHASE_SEQUENCER -- requirements
Module: traffic_phase_sequencer

Interface
REQ-001 SHALL have parameter N_PHASE, default 4, number of signal phases (2..8).
REQ-002 SHALL have parameter CNT_W, default 4, width of the duration counter and of each green-time field.
REQ-003 SHALL have parameter TICK_DIV, default 1, clk cycles per timing tick (1..2^16).
REQ-004 SHALL have parameter T_YEL, default 3, yellow duration in ticks (>=1).
REQ-005 SHALL have parameter T_RED_CLR, default 1, all-red clearance in ticks (>=1).
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on the rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-008 SHALL have port green_time, input, N_PHASE*CNT_W, green duration in ticks; phase p uses bits [CNT_W*p+CNT_W-1 : CNT_W*p].
REQ-009 SHALL have port demand, input, N_PHASE, per-phase service request; bit 0 is ignored because phase 0 is always served.
REQ-010 SHALL have port night_mode, input, 1, request for flashing operation.
REQ-011 SHALL have port light, output, N_PHASE*3, lamp drive; phase p uses bits [3p+2:3p] = {red, yellow, green}.
REQ-012 SHALL have port phase, output, max(1,clog2(N_PHASE)), index of the active phase.
REQ-013 SHALL have port ps, output, 2, FSM state: 0 ALLRED, 1 GREEN, 2 YELLOW, 3 FLASH.
REQ-014 SHALL have port count, output, CNT_W, remaining ticks in the current state minus one.

Function
REQ-015 SHALL use a tick divider that counts 0..TICK_DIV-1 and asserts tick in the cycle it equals TICK_DIV-1; with TICK_DIV=1, tick is asserted every cycle.
REQ-016 SHALL load count with (duration-1) on entry to each state and decrement it on every tick; the state ends on a tick with count==0.
REQ-017 SHALL sample green_time for the entered phase on GREEN entry; a value of 0 SHALL be treated as 1.
REQ-018 SHALL make ALLRED last T_RED_CLR ticks with every phase at 3'b100.
REQ-019 SHALL, at ALLRED end, enter FLASH if night_mode=1; otherwise enter GREEN on the next phase.
REQ-020 SHALL choose the next phase by cyclic search from phase+1 for the first index with a demand bit set, with phase 0 always eligible; the search wraps past N_PHASE-1.
REQ-021 SHALL, at GREEN end, re-enter GREEN on the same phase with count reloaded and no yellow if the selected next phase equals the current phase and night_mode=0; otherwise it SHALL enter YELLOW.
REQ-022 SHALL drive the active phase 3'b001 in GREEN and 3'b010 in YELLOW, with all other phases at 3'b100.
REQ-023 SHALL make YELLOW last T_YEL ticks and then enter ALLRED.
REQ-024 SHALL, in FLASH, toggle a blink bit every tick: phase 0 alternates 3'b010/3'b000 and other phases alternate 3'b100/3'b000; the first FLASH tick period is lit.
REQ-025 SHALL, on a tick in FLASH with night_mode=0, enter ALLRED with the next phase forced to 0.
REQ-026 SHALL only act on night_mode at ALLRED end, at GREEN end, or in FLASH; a GREEN in progress SHALL complete, followed by YELLOW.
REQ-027 SHALL register all outputs, and light SHALL never show green on two phases at once.

Reset
REQ-028 SHALL, when rst=0 at a clk edge, set ps=ALLRED, phase=0, count=T_RED_CLR-1, divider=0, blink=0, and light all-red (12'h924 for N_PHASE=4), overriding any state including mid-YELLOW.
REQ-029 SHALL, after rst returns to 1, serve ALLRED for T_RED_CLR ticks and then GREEN on phase 0.

Verification (N_PHASE=4, TICK_DIV=1, T_YEL=3, T_RED_CLR=1, green_time all 5)
REQ-030 SHALL cover reset: rst=0 for 2 cycles -> light=12'h924 and ps=0; after release, 1 cycle ALLRED, then phase 0 green (light=12'h921) for 5 cycles.
REQ-031 SHALL cover full rotation: demand=4'b1110 -> phase order 0,1,2,3,0 with each phase serving 5 green, 3 yellow and 1 all-red cycles, giving a 36-cycle period.
REQ-032 SHALL cover skip and hold: demand=4'b0100 -> phases 0,2,0 with 1 and 3 never green; then demand=4'b0000 -> phase 0 stays green continuously, count reloads to 4, and ps never equals 2.
REQ-033 SHALL cover night mode: night_mode=1 mid-green of phase 1 -> phase 1 finishes green, then yellow, then all-red, then ps=3 with phase 0 toggling 010/000 each cycle and others 100/000; night_mode=0 -> 1 cycle ALLRED, then phase 0 green.
REQ-034 SHALL cover zero duration and divider: green_time phase 2 = 0 -> phase 2 green for exactly 1 tick; TICK_DIV=4 -> every state duration is scaled by 4 clk cycles.
REQ-035 SHALL cover reset mid-operation: rst=0 during phase 3 yellow -> next edge shows light=12'h924, ps=0, phase=0.
